// File: rtl/wishbone_arbiter.sv
// wishbone_arbiter: N-master to single-slave Wishbone arbiter with registered one-hot grant.
// Define WB_ARB_TIMEOUT_EN to add the stb-without-ack watchdog (error pulse + forced release).
module wishbone_arbiter #(
   parameter int N_MASTERS      = 3,
   parameter int ADDRESS_WIDTH  = 16,
   parameter int DATA_WIDTH     = 8,
   parameter int DATA_BYTES     = 1,
   parameter int ROUND_ROBIN    = 0,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [N_MASTERS-1:0]              m_cyc_i,
   input  logic [N_MASTERS-1:0]              m_stb_i,
   input  logic [N_MASTERS-1:0]              m_we_i,
   input  logic [N_MASTERS*ADDRESS_WIDTH-1:0] m_adr_i,
   input  logic [N_MASTERS*DATA_WIDTH-1:0]   m_dat_i,
   input  logic [N_MASTERS*DATA_BYTES-1:0]   m_sel_i,
   input  logic [N_MASTERS*3-1:0]            m_cti_i,
   output logic [DATA_WIDTH-1:0]             m_dat_o,
   output logic [N_MASTERS-1:0]              m_ack_o,
   output logic [N_MASTERS-1:0]              m_err_o,
   output logic [N_MASTERS-1:0]              m_gnt_o,
   output logic [N_MASTERS-1:0]              m_busy_o,
   output logic                              s_cyc_o,
   output logic                              s_stb_o,
   output logic                              s_we_o,
   output logic [ADDRESS_WIDTH-1:0]          s_adr_o,
   output logic [DATA_WIDTH-1:0]             s_dat_o,
   output logic [DATA_BYTES-1:0]             s_sel_o,
   output logic [2:0]                        s_cti_o,
   input  logic [DATA_WIDTH-1:0]             s_dat_i,
   input  logic                              s_ack_i
);

   localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

   typedef enum logic {
      S_IDLE,
      S_OWNED
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [N_MASTERS-1:0] r_gnt;
   logic [N_MASTERS-1:0] w_gnt_nxt;
   logic [IW-1:0]        r_last;
   logic [IW-1:0]        w_last_nxt;
   logic [N_MASTERS-1:0] w_req;
   logic [IW-1:0]        w_win;
   logic                 w_any;
   logic                 w_own_cyc;
   logic                 w_own_stb;
   logic                 w_to;

   // Distance from the preferred start point; smallest distance wins.
   always_comb begin : p_pick
      int v_d;
      int v_best;
      w_win  = '0;
      w_any  = 1'b0;
      v_best = N_MASTERS;
      for (int i = 0; i < N_MASTERS; i++) begin
         v_d = i;
         if (ROUND_ROBIN != 0) begin
            v_d = i - int'(r_last) - 1;
            if (v_d < 0) v_d = v_d + N_MASTERS;
         end
         if (w_req[i] && (v_d < v_best)) begin
            v_best = v_d;
            w_win  = IW'(i);
            w_any  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_gnt   <= '0;
         r_last  <= IW'(N_MASTERS - 1);
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_gnt_nxt;
         r_last  <= w_last_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_last_nxt  = r_last;
      unique case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_state_nxt = S_OWNED;
               w_gnt_nxt   = N_MASTERS'(1) << w_win;
               w_last_nxt  = w_win;
            end
         end
         S_OWNED: begin
            if (!w_own_cyc || w_to) begin
               w_state_nxt = S_IDLE;
               w_gnt_nxt   = '0;
            end
         end
      endcase
   end

   // Grant is one-hot or zero, so an AND-OR mux yields zeros when idle.
   always_comb begin
      w_own_cyc = |(r_gnt & m_cyc_i);
      w_own_stb = |(r_gnt & m_stb_i);
      s_we_o    = |(r_gnt & m_we_i);
      s_adr_o   = '0;
      s_dat_o   = '0;
      s_sel_o   = '0;
      s_cti_o   = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
         if (r_gnt[i]) begin
            s_adr_o = s_adr_o | m_adr_i[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            s_dat_o = s_dat_o | m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
            s_sel_o = s_sel_o | m_sel_i[i*DATA_BYTES +: DATA_BYTES];
            s_cti_o = s_cti_o | m_cti_i[i*3 +: 3];
         end
      end
   end

   assign s_cyc_o  = w_own_cyc & ~w_to;
   assign s_stb_o  = s_cyc_o & w_own_stb;
   assign m_dat_o  = s_dat_i;
   assign m_ack_o  = s_ack_i ? r_gnt : '0;
   assign m_gnt_o  = r_gnt;
   assign m_busy_o = (r_state == S_OWNED) ? ~r_gnt : '0;

`ifdef WB_ARB_TIMEOUT_EN
   logic [7:0]           r_cnt;
   logic [N_MASTERS-1:0] r_excl;

   assign w_to    = (r_state == S_OWNED) && (r_cnt == 8'(TIMEOUT_CYCLES));
   assign w_req   = m_cyc_i & ~r_excl;
   assign m_err_o = w_to ? r_gnt : '0;

   // A timed-out master stays excluded until it has dropped cyc.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt  <= '0;
         r_excl <= '0;
      end else begin
         r_excl <= (r_excl | (w_to ? r_gnt : '0)) & m_cyc_i;
         if ((r_state != S_OWNED) || s_ack_i || w_to) begin
            r_cnt <= '0;
         end else if (s_stb_o) begin
            r_cnt <= r_cnt + 8'd1;
         end
      end
   end
`else
   logic [7:0] w_unused_to;

   assign w_unused_to = 8'(TIMEOUT_CYCLES);
   assign w_to        = 1'b0;
   assign w_req       = m_cyc_i;
   assign m_err_o     = '0;
`endif

endmodule

// File: tb/tb_wishbone_arbiter.sv
// tb_wishbone_arbiter: fixed-priority and round-robin instances driven with shared
// random/directed stimulus, checked by a scoreboard fed from a transaction-level model.
`timescale 1ns/1ps
module tb_wishbone_arbiter;

   localparam int N  = 3;
   localparam int AW = 16;
   localparam int DW = 8;
   localparam int DB = 1;
   localparam int TO = 16;

   typedef struct packed {
      logic [N-1:0]  gnt;
      logic [N-1:0]  ack;
      logic [N-1:0]  busy;
      logic [N-1:0]  err;
      logic          scyc;
      logic          sstb;
      logic          swe;
      logic [AW-1:0] adr;
      logic [DW-1:0] sdat;
      logic [DW-1:0] mdat;
      logic [DB-1:0] sel;
      logic [2:0]    cti;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  cyc;
   logic [N-1:0]  stb;
   logic [N-1:0]  we;
   logic [AW-1:0] adr_a [N];
   logic [DW-1:0] dat_a [N];
   logic [DB-1:0] sel_a [N];
   logic [2:0]    cti_a [N];
   logic [DW-1:0] sdat;
   logic          sack;

   logic [N*AW-1:0] adr_b;
   logic [N*DW-1:0] dat_b;
   logic [N*DB-1:0] sel_b;
   logic [N*3-1:0]  cti_b;

   logic [DW-1:0] mdat_o [2];
   logic [N-1:0]  ack_o  [2];
   logic [N-1:0]  err_o  [2];
   logic [N-1:0]  gnt_o  [2];
   logic [N-1:0]  busy_o [2];
   logic          scyc_o [2];
   logic          sstb_o [2];
   logic          swe_o  [2];
   logic [AW-1:0] sadr_o [2];
   logic [DW-1:0] sdat_o [2];
   logic [DB-1:0] ssel_o [2];
   logic [2:0]    scti_o [2];

   int own  [2];
   int last [2];
   int cnt  [2];
   logic [N-1:0] excl [2];

   exp_t q0[$];
   exp_t q1[$];
   int   n_pass  = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign adr_b[g*AW +: AW] = adr_a[g];
      assign dat_b[g*DW +: DW] = dat_a[g];
      assign sel_b[g*DB +: DB] = sel_a[g];
      assign cti_b[g*3 +: 3]   = cti_a[g];
   end

   for (genvar m = 0; m < 2; m++) begin : g_dut
      wishbone_arbiter #(
         .N_MASTERS     (N),
         .ADDRESS_WIDTH (AW),
         .DATA_WIDTH    (DW),
         .DATA_BYTES    (DB),
         .ROUND_ROBIN   (m),
         .TIMEOUT_CYCLES(TO)
      ) dut (
         .clk_i   (clk),
         .rst_i   (rst),
         .m_cyc_i (cyc),
         .m_stb_i (stb),
         .m_we_i  (we),
         .m_adr_i (adr_b),
         .m_dat_i (dat_b),
         .m_sel_i (sel_b),
         .m_cti_i (cti_b),
         .m_dat_o (mdat_o[m]),
         .m_ack_o (ack_o[m]),
         .m_err_o (err_o[m]),
         .m_gnt_o (gnt_o[m]),
         .m_busy_o(busy_o[m]),
         .s_cyc_o (scyc_o[m]),
         .s_stb_o (sstb_o[m]),
         .s_we_o  (swe_o[m]),
         .s_adr_o (sadr_o[m]),
         .s_dat_o (sdat_o[m]),
         .s_sel_o (ssel_o[m]),
         .s_cti_o (scti_o[m]),
         .s_dat_i (sdat),
         .s_ack_i (sack)
      );
   end

   function automatic int pick(input logic [N-1:0] req, input int lst, input bit rr);
      if (rr) begin
         for (int k = 1; k <= N; k++) begin
            if (req[(lst + k) % N]) return (lst + k) % N;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (req[i]) return i;
         end
      end
      return -1;
   endfunction

   function automatic bit timed_out(input int m);
`ifdef WB_ARB_TIMEOUT_EN
      return (own[m] >= 0) && (cnt[m] == TO);
`else
      return (m < 0);
`endif
   endfunction

   function automatic exp_t expect_of(input int m);
      exp_t e;
      int   o;
      bit   to;
      o      = own[m];
      to     = timed_out(m);
      e      = '0;
      e.mdat = sdat;
      if (o >= 0) begin
         e.gnt  = N'(1) << o;
         e.busy = ~e.gnt;
         e.ack  = sack ? e.gnt : '0;
         e.err  = to ? e.gnt : '0;
         e.scyc = cyc[o] && !to;
         e.sstb = e.scyc && stb[o];
         e.swe  = we[o];
         e.adr  = adr_a[o];
         e.sdat = dat_a[o];
         e.sel  = sel_a[o];
         e.cti  = cti_a[o];
      end
      return e;
   endfunction

   task automatic model_edge();
      for (int m = 0; m < 2; m++) begin
         int           o;
         int           w;
         bit           to;
         logic [N-1:0] req;
         o   = own[m];
         to  = timed_out(m);
         req = cyc;
         if (rst) begin
            own[m]  = -1;
            last[m] = N - 1;
            cnt[m]  = 0;
            excl[m] = '0;
         end else begin
`ifdef WB_ARB_TIMEOUT_EN
            req = cyc & ~excl[m];
            if (o < 0 || sack || to) cnt[m] = 0;
            else if (cyc[o] && stb[o]) cnt[m] = cnt[m] + 1;
            excl[m] = (excl[m] | (to ? N'(1) << o : '0)) & cyc;
`endif
            if (o < 0) begin
               w = pick(req, last[m], m == 1);
               if (w >= 0) begin
                  own[m]  = w;
                  last[m] = w;
               end
            end else if (to || !cyc[o]) begin
               own[m] = -1;
            end
         end
      end
   endtask

   task automatic adv();
      @(posedge clk);
      model_edge();
      #1;
      for (int i = 0; i < N; i++) begin
         adr_a[i] = AW'($urandom);
         dat_a[i] = DW'($urandom);
         sel_a[i] = DB'($urandom);
         cti_a[i] = 3'($urandom);
      end
      sdat = DW'($urandom);
   endtask

   task automatic commit();
      q0.push_back(expect_of(0));
      q1.push_back(expect_of(1));
   endtask

   task automatic chk(input string nm, input int m,
                      input logic [31:0] act, input logic [31:0] exp);
      n_total = n_total + 1;
      if (act === exp) n_pass = n_pass + 1;
      else $display("FAIL %s (rr=%0d) at %0t: got %h expected %h", nm, m, $time, act, exp);
   endtask

   task automatic compare(input int m, input exp_t e);
      chk("gnt",   m, 32'(gnt_o[m]),  32'(e.gnt));
      chk("ack",   m, 32'(ack_o[m]),  32'(e.ack));
      chk("busy",  m, 32'(busy_o[m]), 32'(e.busy));
      chk("err",   m, 32'(err_o[m]),  32'(e.err));
      chk("s_cyc", m, 32'(scyc_o[m]), 32'(e.scyc));
      chk("s_stb", m, 32'(sstb_o[m]), 32'(e.sstb));
      chk("s_we",  m, 32'(swe_o[m]),  32'(e.swe));
      chk("s_adr", m, 32'(sadr_o[m]), 32'(e.adr));
      chk("s_dat", m, 32'(sdat_o[m]), 32'(e.sdat));
      chk("s_sel", m, 32'(ssel_o[m]), 32'(e.sel));
      chk("s_cti", m, 32'(scti_o[m]), 32'(e.cti));
      chk("m_dat", m, 32'(mdat_o[m]), 32'(e.mdat));
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q0.size() > 0) begin
         e = q0.pop_front();
         compare(0, e);
      end
      if (q1.size() > 0) begin
         e = q1.pop_front();
         compare(1, e);
      end
   end

   logic [N-1:0] d_cyc [10] = '{3'b110, 3'b110, 3'b110, 3'b110, 3'b110,
                                3'b100, 3'b100, 3'b100, 3'b000, 3'b000};
   logic         d_ack [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

   initial begin
      bit ackd;
      int prev;
      rst  = 1'b1;
      cyc  = '0;
      stb  = '0;
      we   = '0;
      sack = 1'b0;
      sdat = '0;
      for (int i = 0; i < N; i++) begin
         adr_a[i] = '0;
         dat_a[i] = '0;
         sel_a[i] = '0;
         cti_a[i] = '0;
         own[i % 2]  = -1;
      end
      for (int m = 0; m < 2; m++) begin
         own[m]  = -1;
         last[m] = N - 1;
         cnt[m]  = 0;
         excl[m] = '0;
      end
      adv();
      commit();
      adv();
      rst = 1'b0;
      commit();

      for (int t = 0; t < 10; t++) begin
         adv();
         cyc      = d_cyc[t];
         stb      = d_cyc[t];
         we       = 3'b010;
         sack     = d_ack[t];
         adr_a[1] = 16'h8004;
         commit();
      end

      ackd = 1'b0;
      prev = 0;
      for (int t = 0; t < 16; t++) begin
         adv();
         cyc  = '1;
         stb  = '1;
         sack = 1'b0;
         if (ackd) begin
            cyc[prev] = 1'b0;
            ackd      = 1'b0;
         end else if (own[1] >= 0) begin
            sack = 1'b1;
            ackd = 1'b1;
            prev = own[1];
         end
         commit();
      end

      for (int t = 0; t < 9; t++) begin
         adv();
         sack = 1'b0;
         cyc  = (t < 2) ? 3'b000 : (t < 5) ? 3'b100 : 3'b111;
         stb  = cyc;
         rst  = (t == 5);
         commit();
      end

`ifdef WB_ARB_TIMEOUT_EN
      for (int t = 0; t < 28; t++) begin
         adv();
         cyc  = (t < 3) ? 3'b000 : 3'b011;
         stb  = cyc;
         sack = 1'b0;
         commit();
      end
`endif

      for (int t = 0; t < 600; t++) begin
         adv();
         for (int i = 0; i < N; i++) begin
            if (!cyc[i]) cyc[i] = ($urandom_range(0, 2) == 0);
            else if ($urandom_range(0, 4) == 0) cyc[i] = 1'b0;
            stb[i] = cyc[i] & 1'($urandom_range(0, 1));
            we[i]  = 1'($urandom_range(0, 1));
         end
         sack = ($urandom_range(0, 2) == 0);
         rst  = ($urandom_range(0, 149) == 0);
         commit();
      end

      @(negedge clk);
      @(negedge clk);
      #1;
      chk("queue_drain", 0, 32'(q0.size() + q1.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/wishbone_arbiter.md
Name: wishbone_arbiter

Overview:
- Parametrised N-master to one-slave-segment Wishbone arbiter for the frame/matrix bus.
- Replaces the hand-written cycle-OR blocking and priority mux in the top level.
- Registered grant with cycle locking; selectable fixed-priority or round-robin mode.
- Routes ack and read data back to the owning master only, and gives each master a busy indication compatible with existing master cyc_i inputs.

Parameters:
- N_MASTERS, 3, number of masters (2..8); index 0 is highest priority in fixed mode
- ADDRESS_WIDTH, 16, adr width
- DATA_WIDTH, 8, data width
- DATA_BYTES, 1, sel width
- ROUND_ROBIN, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
- TIMEOUT_CYCLES, 255, stb-without-ack limit; used only with WB_ARB_TIMEOUT_EN; 8-bit counter

Ports:
- clk_i  in  1  bus clock
- rst_i  in  1  synchronous active-high reset
- m_cyc_i  in  N_MASTERS  per-master cyc
- m_stb_i  in  N_MASTERS  per-master stb
- m_we_i  in  N_MASTERS  per-master we
- m_adr_i  in  N_MASTERS*ADDRESS_WIDTH  packed; master i at [i*AW +: AW]
- m_dat_i  in  N_MASTERS*DATA_WIDTH  packed write data
- m_sel_i  in  N_MASTERS*DATA_BYTES  packed sel
- m_cti_i  in  N_MASTERS*3  packed cti
- m_dat_o  out  DATA_WIDTH  read data broadcast (= s_dat_i)
- m_ack_o  out  N_MASTERS  ack routed to owner only
- m_err_o  out  N_MASTERS  timeout error pulse (0 without feature)
- m_gnt_o  out  N_MASTERS  one-hot registered grant
- m_busy_o  out  N_MASTERS  bus owned by another master (drive into existing masters' cyc_i)
- s_cyc_o, s_stb_o, s_we_o  out  1  slave-side controls
- s_adr_o  out  ADDRESS_WIDTH  slave address
- s_dat_o  out  DATA_WIDTH  slave write data
- s_sel_o  out  DATA_BYTES  slave sel
- s_cti_o  out  3  slave cti
- s_dat_i  in  DATA_WIDTH  OR/muxed slave read data
- s_ack_i  in  1  OR of slave acks

Behaviour:
- State machine: IDLE, OWNED.
  - IDLE: if any m_cyc_i is set, register the winner → OWNED, gnt = onehot(winner). Grant latency: 1 cycle from cyc to m_gnt_o.
  - OWNED: hold the grant while m_cyc_i[owner] = 1, with no preemption.
  - Owner drops cyc at edge k: gnt clears at edge k+1 (→ IDLE). The earliest new grant is edge k+2, so there is one dead cycle between owners.
- Fixed mode: lowest set index wins.
- Round-robin mode: search from last_owner+1, wrapping modulo N_MASTERS. last_owner updates on every grant.
  - Reset value of last_owner is N_MASTERS-1, so master 0 is preferred first.
- Slave outputs are combinational from the registered owner index:
  - s_cyc_o = OWNED & m_cyc_i[owner]; s_stb_o = s_cyc_o & m_stb_i[owner].
  - adr, dat, we, sel and cti are muxed from the owner. All are 0 when not OWNED.
- m_ack_o[i] = s_ack_i & gnt[i]. An ack arriving with no owner is dropped.
- m_dat_o = s_dat_i, unconditionally.
- m_busy_o[i] = OWNED & ~gnt[i]. m_busy_o is all-zero in IDLE.
- Simultaneous requests: resolved per mode in a single cycle; only one grant bit is ever set (one-hot or zero).
- Owner drops cyc in the same cycle as ack: the ack is still routed, then release proceeds as above.
- Reset mid-cycle: at the rst_i edge the state goes to IDLE, gnt = 0, last_owner = N_MASTERS-1, timeout counter = 0.
- Reset values: all slave outputs 0; m_ack_o, m_err_o, m_gnt_o and m_busy_o are 0.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter increments each cycle that s_stb_o = 1 and s_ack_i = 0, and clears on ack or on grant change.
  - When the counter reaches TIMEOUT_CYCLES, m_err_o[owner] pulses for 1 cycle.
  - On that cycle s_cyc_o and s_stb_o are forced to 0, and the grant is released → IDLE on the next edge. This happens even if the master still holds cyc.
  - The master must drop cyc before it can be regranted.
  - The timed-out master is excluded from the next arbitration until its m_cyc_i has been 0 for one or more cycles.
- Undefined: no counter logic; m_err_o tied to 0; a hung slave holds the bus indefinitely.

Test Plan:
- Fixed mode, N=3: m_cyc_i = 3'b110 at cycle 0 → m_gnt_o = 3'b010 at cycle 1. s_adr_o equals master 1's adr (e.g. 0x8004). m_busy_o = 3'b101.
- Owner 1 single write; s_ack_i pulses at cycle 4 → m_ack_o = 3'b010 for that cycle only. Master 1 drops cyc at cycle 5 → gnt = 0 at cycle 6, gnt = 3'b100 at cycle 7.
- Round-robin, all three cyc held high and each master dropping cyc after one ack → grant order 0,1,2,0. There is 1 dead cycle between each grant; the grant is never 2-hot.
- rst_i asserted while master 2 owns with stb high → next cycle gnt = 0 and s_cyc_o = 0. After reset, round-robin with 3'b111 requested grants master 0.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 16: owner 0 strobes with no ack → m_err_o = 3'b001 pulses 16 cycles after stb. s_cyc_o = 0 on that cycle. Master 1 (requesting) is granted 2 cycles later.
- Stray s_ack_i = 1 in IDLE → m_ack_o stays 0 and the state is unchanged.
